// File: rtl/spi_master_shifter_if.sv
// ---------------------------------------------------------------------------
// spi_master_shifter_if
// Groups every non-clock/reset signal of the SPI master shift engine.
//   master modport : the shift engine itself
//   slave  modport : the surrounding environment (register side, pads,
//                    external bit counter)
// Signals:
//   start, tx_data   request strobe and byte to transmit
//   busy, done       frame status / end-of-frame pulse
//   rx_data          received byte
//   sclk, mosi, miso SPI pins; cs_n chip select (active-low)
//   cnt_en           enable pulse to the external bit counter
//   cnt_value        external bit counter value (0..8)
// ---------------------------------------------------------------------------
interface spi_master_shifter_if;
   logic       start;
   logic [7:0] tx_data;
   logic       busy;
   logic       done;
   logic [7:0] rx_data;
   logic       sclk;
   logic       mosi;
   logic       miso;
   logic       cs_n;
   logic       cnt_en;
   logic [3:0] cnt_value;

   modport master (
      input  start, tx_data, miso, cnt_value,
      output busy, done, rx_data, sclk, mosi, cs_n, cnt_en
   );

   modport slave (
      output start, tx_data, miso, cnt_value,
      input  busy, done, rx_data, sclk, mosi, cs_n, cnt_en
   );
endinterface

// File: rtl/spi_master_shifter.sv
// ---------------------------------------------------------------------------
// spi_master_shifter
// Byte-wide SPI mode-0 master shift engine. Sends tx_data MSB first on mosi,
// captures miso on each sclk rise, and drives the external 4-bit bit counter
// through cnt_en, ending the frame when that counter reports 8.
// Ports:
//   clk   system clock, rising edge
//   reset asynchronous, active-low
//   bus   spi_master_shifter_if.master (start/tx_data/busy/done/rx_data,
//         sclk/mosi/miso/cs_n, cnt_en/cnt_value)
// Parameter:
//   CLK_DIV  sclk half-period in clk cycles (1..255)
// Build option:
//   SPI_LOOPBACK_EN  when defined, the receive shifter samples the internal
//                    mosi instead of the miso pin.
// All outputs are registered.
// ---------------------------------------------------------------------------
module spi_master_shifter #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   spi_master_shifter_if.master  bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_HIGH  = 3'd2,
      ST_LOW   = 3'd3,
      ST_HOLD  = 3'd4
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t     state_r, state_s;
   logic [7:0] div_r, div_s;
   logic [7:0] tx_sr_r, tx_sr_s;
   logic [7:0] rx_sr_r, rx_sr_s;
   logic [7:0] rx_data_r, rx_data_s;
   logic       sclk_r, sclk_s;
   logic       mosi_r, mosi_s;
   logic       cs_n_r, cs_n_s;
   logic       busy_r, busy_s;
   logic       done_r, done_s;
   logic       cnt_en_r, cnt_en_s;
   logic       div_last_s;
   logic       last_bit_s;
   logic       can_accept_s;
   logic       sample_s;

`ifdef SPI_LOOPBACK_EN
   assign sample_s = mosi_r;
`else
   assign sample_s = bus.miso;
`endif

   assign div_last_s   = (div_r == DIV_LAST);
   // A fresh frame needs the counter idle (0 after reset, 8 after a frame)
   // so exactly eight enables bring it back to 8.
   assign can_accept_s = (bus.cnt_value == 4'd0) || (bus.cnt_value == 4'd8);
   // With CLK_DIV=1 the enable pulse is still high in the deciding cycle and
   // the counter has not yet stepped, so 7 then means "about to become 8".
   assign last_bit_s   = cnt_en_r ? (bus.cnt_value == 4'd7) : (bus.cnt_value == 4'd8);

   // State register and all registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= ST_IDLE;
         div_r     <= 8'h00;
         tx_sr_r   <= 8'h00;
         rx_sr_r   <= 8'h00;
         rx_data_r <= 8'h00;
         sclk_r    <= 1'b0;
         mosi_r    <= 1'b0;
         cs_n_r    <= 1'b1;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         cnt_en_r  <= 1'b0;
      end else begin
         state_r   <= state_s;
         div_r     <= div_s;
         tx_sr_r   <= tx_sr_s;
         rx_sr_r   <= rx_sr_s;
         rx_data_r <= rx_data_s;
         sclk_r    <= sclk_s;
         mosi_r    <= mosi_s;
         cs_n_r    <= cs_n_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         cnt_en_r  <= cnt_en_s;
      end
   end

   // Next-state and next-output logic; pulses default low, everything else holds.
   always_comb begin
      state_s   = state_r;
      div_s     = div_r + 8'd1;
      tx_sr_s   = tx_sr_r;
      rx_sr_s   = rx_sr_r;
      rx_data_s = rx_data_r;
      sclk_s    = sclk_r;
      mosi_s    = mosi_r;
      cs_n_s    = cs_n_r;
      busy_s    = busy_r;
      done_s    = 1'b0;
      cnt_en_s  = 1'b0;

      case (state_r)
         ST_IDLE: begin
            div_s = 8'h00;
            if (bus.start && can_accept_s) begin
               tx_sr_s = bus.tx_data;
               mosi_s  = bus.tx_data[7];
               cs_n_s  = 1'b0;
               busy_s  = 1'b1;
               state_s = ST_SETUP;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            if (div_last_s) begin
               state_s = ST_HIGH;
               div_s   = 8'h00;
               sclk_s  = 1'b1;
               rx_sr_s = {rx_sr_r[6:0], sample_s};
            end else begin
               state_s = ST_SETUP;
            end
         end
         ST_HIGH: begin
            if (div_last_s) begin
               state_s  = ST_LOW;
               div_s    = 8'h00;
               sclk_s   = 1'b0;
               cnt_en_s = 1'b1;
               tx_sr_s  = {tx_sr_r[6:0], 1'b0};
               mosi_s   = tx_sr_r[6];
            end else begin
               state_s = ST_HIGH;
            end
         end
         ST_LOW: begin
            if (div_last_s && last_bit_s) begin
               state_s = ST_HOLD;
               div_s   = 8'h00;
            end else if (div_last_s) begin
               state_s = ST_HIGH;
               div_s   = 8'h00;
               sclk_s  = 1'b1;
               rx_sr_s = {rx_sr_r[6:0], sample_s};
            end else begin
               state_s = ST_LOW;
            end
         end
         ST_HOLD: begin
            // Leaving HOLD is the done cycle: the engine is already back in IDLE.
            if (div_last_s) begin
               state_s   = ST_IDLE;
               div_s     = 8'h00;
               cs_n_s    = 1'b1;
               rx_data_s = rx_sr_r;
               done_s    = 1'b1;
               busy_s    = 1'b0;
            end else begin
               state_s = ST_HOLD;
            end
         end
         default: begin
            state_s = ST_IDLE;
            div_s   = 8'h00;
         end
      endcase
   end

   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
   assign bus.rx_data = rx_data_r;
   assign bus.sclk    = sclk_r;
   assign bus.mosi    = mosi_r;
   assign bus.cs_n    = cs_n_r;
   assign bus.cnt_en  = cnt_en_r;

endmodule

// File: doc/spi_master_shifter.md
# spi_master_shifter

Byte-wide SPI mode-0 master shift engine that sits directly downstream of the 4-bit bit counter (counts 1..8, wraps 8→1, clears to 0 on reset). It accepts a byte on a start strobe, drives `sclk`/`mosi`/`cs_n`, and captures `miso` into a receive byte. It pulses the counter's enable once per bit and ends the frame when the counter reports 8. It is the core of the team's SPI master datapath, between the register interface and the pads.

## Interface
Parameters:
- `CLK_DIV`, default 4: SCLK half-period in `clk` cycles; legal range 1..255.

Ports:
- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  asynchronous, active-low; also resets the bit counter.
- `start`  input  1  level-sampled request; accepted only in IDLE.
- `tx_data`  input  8  byte to send, MSB first; captured on accept.
- `busy`  output  1  high from the accept edge until the cycle `done` pulses.
- `done`  output  1  one-cycle pulse at frame end.
- `rx_data`  output  8  received byte; updated in the `done` cycle, held otherwise.
- `sclk`  output  1  SPI clock; idle low.
- `mosi`  output  1  serial data out.
- `miso`  input  1  serial data in.
- `cs_n`  output  1  chip select, active-low.
- `cnt_en`  output  1  one-cycle enable pulse to the bit counter.
- `cnt_value`  input  4  bit-counter output.

## Operation
- Reset values: `sclk`=0, `mosi`=0, `cs_n`=1, `busy`=0, `done`=0, `cnt_en`=0, `rx_data`=8'h00. Reset also sets state to IDLE and clears the shift registers and divider.
- The divider counts `CLK_DIV` cycles per segment and restarts on every state entry.
- IDLE:
  - If `start`=1 and `cnt_value` is 0 or 8: load tx shift reg ← `tx_data`, set `mosi` ← `tx_data[7]`, `cs_n` ← 0, `busy` ← 1, go to SETUP.
  - Otherwise stay in IDLE. `start` is ignored for `cnt_value` 1..7.
- SETUP: hold for `CLK_DIV` cycles, then go to HIGH.
- HIGH:
  - On entry, `sclk` ← 1 and `miso` is shifted into the LSB of the rx shift reg.
  - Hold for `CLK_DIV` cycles, then go to LOW.
- LOW:
  - On entry, `sclk` ← 0, `cnt_en`=1 for exactly one cycle, tx shift reg shifts left, and `mosi` ← next bit.
  - At the last divider cycle: if `cnt_value`==8, go to HOLD; else go to HIGH.
- HOLD: `cs_n` stays 0 for `CLK_DIV` cycles, then `cs_n` ← 1 and `rx_data` ← rx shift reg.
- DONE cycle: `done`=1, `busy` ← 0, return to IDLE. A new `start` may be accepted in the cycle after `done`.
- Counter boundary: the first `cnt_en` of a frame takes the counter from 0 (after reset) or from 8 (after the previous frame) to 1. Exactly 8 pulses per frame are guaranteed by the `cnt_value` gating on accept.
- `start` and `tx_data` changes while `busy`=1 have no effect.
- Reset asserted mid-frame: all outputs go immediately to their reset values. No `done` pulse. The partial `rx_data` is discarded (cleared to 0).

## Timing
- Accept edge = cycle 0. First `sclk` rise is at cycle `CLK_DIV`.
- 8 rising edges, spaced 2·`CLK_DIV` apart.
- `mosi` changes only on `sclk` falling edges and on accept. It is stable at least `CLK_DIV` cycles before each rise.
- `cnt_en` is high in the first cycle of each LOW segment.
- `cs_n` rises at cycle 18·`CLK_DIV`. `done` is high in that same cycle.
- Frame length is 18·`CLK_DIV` cycles. Back-to-back frames have a minimum gap of 1 IDLE cycle.

## Configuration
- Macro: `SPI_LOOPBACK_EN`.
- Defined: the rx shift reg samples the internal `mosi` instead of the `miso` port, and `miso` is ignored. Pins and timing are unchanged.
- Undefined: the rx shift reg samples `miso`.

## Test plan
- Reset, then `tx_data`=8'hA5, `start` for 1 cycle, `CLK_DIV`=2, external slave returns 8'h3C:
  - `mosi` shows 1,0,1,0,0,1,0,1 at the 8 `sclk` rises.
  - `rx_data`=8'h3C, `done` at cycle 36.
  - 8 `cnt_en` pulses; `cnt_value` ends at 8.
- Two back-to-back frames, 8'hFF then 8'h00:
  - Second frame accepted while `cnt_value`=8; first `cnt_en` wraps the counter to 1.
  - Second `rx_data` correct; gap between frames is exactly 1 cycle.
- `start` held high and `tx_data` changed to 8'h11 mid-frame (first frame 8'h81): transmitted byte stays 8'h81, and exactly one additional frame starts after `done`.
- Force `cnt_value`=5 in IDLE and pulse `start`: no accept, `busy`=0, `cs_n`=1, `sclk`=0.
- Assert `reset` after the 4th `sclk` rise: on the same edge `cs_n`=1, `sclk`=0, `busy`=0, `rx_data`=0, and `done` never pulses.
- With `SPI_LOOPBACK_EN` defined, `miso` tied to 0, `tx_data`=8'h5A: `rx_data`=8'h5A.
